cpu_ctrl: RTL and testbench

- Hardwired control unit for the 8-bit accumulator CPU.
- Fetches an opcode byte and, when needed, an address byte over the shared bus, then sequences the ALU, AC, PC, AR and memory.
- Drives the ALU function select, alus[3:0], and every register load strobe.
- Waits on a variable-latency memory through a mem_rd/mem_wr – mem_ready handshake.

---
 rtl/cpu_ctrl_pkg.sv | 49 ++++
 rtl/cpu_decode.sv | 43 ++++
 rtl/cpu_ctrl.sv | 135 +++++++++++++
 tb/tb_cpu_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared opcodes, ALU codes and state encodings for the accumulator CPU control unit
package cpu_ctrl_pkg;

   localparam logic [3:0] ALUS_IDLE_DEF = 4'b1111;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDAC = 4'h1;
   localparam logic [3:0] OP_STAC = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_INAC = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_NOT  = 4'h8;
   localparam logic [3:0] OP_XOR  = 4'h9;
   localparam logic [3:0] OP_CLAC = 4'hA;
   localparam logic [3:0] OP_JUMP = 4'hB;
   localparam logic [3:0] OP_JMPZ = 4'hC;
   localparam logic [3:0] OP_JPNZ = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [3:0] ALU_CLAC = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0001;
   localparam logic [3:0] ALU_SUB  = 4'b0010;
   localparam logic [3:0] ALU_INAC = 4'b0011;
   localparam logic [3:0] ALU_AND  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0101;
   localparam logic [3:0] ALU_NOT  = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_LDAC = 4'b1000;

   typedef enum logic [2:0] {
      ST_FETCH_A = 3'd0,
      ST_FETCH_M = 3'd1,
      ST_DECODE  = 3'd2,
      ST_OPND_A  = 3'd3,
      ST_OPND_M  = 3'd4,
      ST_EXEC_M  = 3'd5,
      ST_EXEC    = 3'd6,
      ST_HALT    = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      JC_ALWAYS = 2'd0,
      JC_Z      = 2'd1,
      JC_NZ     = 2'd2
   } jump_cond_t;

endpackage

// File: rtl/cpu_decode.sv
// rtl/cpu_decode.sv - combinational opcode classifier feeding the control FSM
module cpu_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [3:0]  opcode,
   output logic [3:0]  alu_code,
   output logic        has_operand,
   output logic        is_store,
   output logic        is_jump,
   output jump_cond_t  jump_cond,
   output logic        is_halt,
   output logic        ac_write
);

   always_comb begin
      alu_code    = ALU_CLAC;
      has_operand = 1'b0;
      is_store    = 1'b0;
      is_jump     = 1'b0;
      jump_cond   = JC_ALWAYS;
      is_halt     = 1'b0;
      ac_write    = 1'b0;
      case (opcode)
         OP_LDAC: begin alu_code = ALU_LDAC; has_operand = 1'b1; end
         OP_STAC: begin has_operand = 1'b1; is_store = 1'b1; end
         OP_ADD:  begin alu_code = ALU_ADD;  has_operand = 1'b1; end
         OP_SUB:  begin alu_code = ALU_SUB;  has_operand = 1'b1; end
         OP_AND:  begin alu_code = ALU_AND;  has_operand = 1'b1; end
         OP_OR:   begin alu_code = ALU_OR;   has_operand = 1'b1; end
         OP_XOR:  begin alu_code = ALU_XOR;  has_operand = 1'b1; end
         // single-byte ALU ops write AC straight from EXEC
         OP_INAC: begin alu_code = ALU_INAC; ac_write = 1'b1; end
         OP_NOT:  begin alu_code = ALU_NOT;  ac_write = 1'b1; end
         OP_CLAC: begin alu_code = ALU_CLAC; ac_write = 1'b1; end
         OP_JUMP: begin has_operand = 1'b1; is_jump = 1'b1; jump_cond = JC_ALWAYS; end
         OP_JMPZ: begin has_operand = 1'b1; is_jump = 1'b1; jump_cond = JC_Z; end
         OP_JPNZ: begin has_operand = 1'b1; is_jump = 1'b1; jump_cond = JC_NZ; end
         OP_HALT: is_halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - hardwired fetch/decode/execute sequencer for the 8-bit accumulator CPU
module cpu_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter logic [3:0] ALUS_IDLE = ALUS_IDLE_DEF
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] bus_in,
   input  logic       mem_ready,
   input  logic       z_flag,
   output logic [3:0] alus,
   output logic       ac_ld,
   output logic       ac_oe,
   output logic       ar_ld,
   output logic       ar_sel,
   output logic       pc_inc,
   output logic       pc_ld,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       halted,
   output logic [2:0] state_dbg
);

   state_t      state, state_nx;
   logic [7:0]  ir;
   logic [3:0]  alu_code;
   logic        has_operand, is_store, is_jump, is_halt, ac_write;
   jump_cond_t  jump_cond;
   logic        jump_taken;
   logic        unused_ir;

   assign unused_ir = ^ir[3:0];

   cpu_decode u_decode (
      .opcode      (ir[7:4]),
      .alu_code    (alu_code),
      .has_operand (has_operand),
      .is_store    (is_store),
      .is_jump     (is_jump),
      .jump_cond   (jump_cond),
      .is_halt     (is_halt),
      .ac_write    (ac_write)
   );

   // z_flag only matters in OPND_M on the ready cycle, where this is consumed
   assign jump_taken = is_jump && ((jump_cond == JC_ALWAYS) ||
                                   (jump_cond == JC_Z  &&  z_flag) ||
                                   (jump_cond == JC_NZ && !z_flag));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FETCH_A;
         ir    <= 8'h00;
      end else begin
         state <= state_nx;
         if (state == ST_FETCH_M && mem_ready)
            ir <= bus_in;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_FETCH_A: state_nx = ST_FETCH_M;
         ST_FETCH_M: if (mem_ready) state_nx = ST_DECODE;
         ST_DECODE:  state_nx = is_halt ? ST_HALT : (has_operand ? ST_OPND_A : ST_EXEC);
         ST_OPND_A:  state_nx = ST_OPND_M;
         ST_OPND_M:  if (mem_ready) state_nx = is_jump ? ST_FETCH_A : ST_EXEC_M;
         ST_EXEC_M:  if (mem_ready) state_nx = ST_FETCH_A;
         ST_EXEC:    state_nx = ST_FETCH_A;
         ST_HALT:    state_nx = ST_HALT;
         default:    state_nx = ST_FETCH_A;
      endcase
   end

   always_comb begin
      alus   = ALUS_IDLE;
      ac_ld  = 1'b0;
      ac_oe  = 1'b0;
      ar_ld  = 1'b0;
      ar_sel = 1'b0;
      pc_inc = 1'b0;
      pc_ld  = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      halted = 1'b0;
      if (!rst) begin
         case (state)
            ST_FETCH_A: ar_ld = 1'b1;
            ST_FETCH_M: begin
               mem_rd = 1'b1;
               pc_inc = mem_ready;
            end
            ST_OPND_A: ar_ld = 1'b1;
            ST_OPND_M: begin
               mem_rd = 1'b1;
               if (mem_ready) begin
                  if (jump_taken) begin
                     pc_ld = 1'b1;
                  end else begin
                     pc_inc = 1'b1;
                     if (!is_jump) begin
                        ar_ld  = 1'b1;
                        ar_sel = 1'b1;
                     end
                  end
               end
            end
            ST_EXEC_M: begin
               if (is_store) begin
                  mem_wr = 1'b1;
                  ac_oe  = 1'b1;
               end else begin
                  mem_rd = 1'b1;
                  alus   = alu_code;
                  ac_ld  = mem_ready;
               end
            end
            ST_EXEC: begin
               if (ac_write) begin
                  alus  = alu_code;
                  ac_ld = 1'b1;
               end
            end
            ST_HALT: halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - randomized self-checking bench for cpu_ctrl against an instruction-level cycle model
module tb_cpu_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] bus_in;
   logic       mem_ready;
   logic       z_flag;
   logic [3:0] alus;
   logic       ac_ld, ac_oe, ar_ld, ar_sel, pc_inc, pc_ld, mem_rd, mem_wr, halted;
   logic [2:0] state_dbg;

   int n_cmp = 0;
   int n_bad = 0;

   cpu_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .bus_in    (bus_in),
      .mem_ready (mem_ready),
      .z_flag    (z_flag),
      .alus      (alus),
      .ac_ld     (ac_ld),
      .ac_oe     (ac_oe),
      .ar_ld     (ar_ld),
      .ar_sel    (ar_sel),
      .pc_inc    (pc_inc),
      .pc_ld     (pc_ld),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .halted    (halted),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   // one record per clock: inputs to apply and outputs the control unit must show
   typedef struct {
      logic       rst;
      logic [7:0] bus;
      logic       rdy;
      logic       z;
      logic [3:0] alus;
      logic       ac_ld, ac_oe, ar_ld, ar_sel, pc_inc, pc_ld, rd, wr, halted;
      logic [2:0] st;
   } cyc_t;

   cyc_t q[$];

   // ALU code per opcode; -1 where the instruction performs no ALU operation
   int alu_tab[16] = '{-1, 8, -1, 1, 2, 3, 4, 5, 6, 7, 0, -1, -1, -1, -1, -1};

   function automatic cyc_t base(input int st);
      cyc_t c;
      c.rst = 1'b0;   c.bus = 8'($urandom); c.rdy = 1'($urandom); c.z = 1'($urandom);
      c.alus = 4'hF;  c.ac_ld = 0; c.ac_oe = 0; c.ar_ld = 0; c.ar_sel = 0;
      c.pc_inc = 0;   c.pc_ld = 0; c.rd = 0; c.wr = 0; c.halted = 0;
      c.st = 3'(st);
      return c;
   endfunction

   function automatic cyc_t rst_cyc(input int st);
      cyc_t c = base(st);
      c.rst = 1'b1;
      c.rdy = 1'b1;
      return c;
   endfunction

   task automatic push_waits(input cyc_t c, input int w);
      cyc_t t;
      repeat (w) begin
         t = c;
         t.rdy = 1'b0;
         t.bus = 8'($urandom);
         t.z   = 1'($urandom);
         q.push_back(t);
      end
   endtask

   task automatic add_instr(input int opc, input int w0, input int w1, input int w2,
                            input bit z, input bit rst_exec);
      cyc_t c;
      bit   operand, taken;
      c = base(0); c.ar_ld = 1; q.push_back(c);
      c = base(1); c.rd = 1; push_waits(c, w0);
      c.rdy = 1; c.bus = {4'(opc), 4'($urandom)}; c.pc_inc = 1; q.push_back(c);
      c = base(2); q.push_back(c);
      if (opc == 15) begin
         repeat (8) begin c = base(7); c.halted = 1; q.push_back(c); end
         q.push_back(rst_cyc(7));
         return;
      end
      operand = (opc inside {1, 2, 3, 4, 6, 7, 9, 11, 12, 13});
      if (!operand) begin
         c = base(6);
         if (alu_tab[opc] >= 0) begin c.alus = 4'(alu_tab[opc]); c.ac_ld = 1; end
         q.push_back(c);
         return;
      end
      c = base(3); c.ar_ld = 1; q.push_back(c);
      c = base(4); c.rd = 1; push_waits(c, w1);
      c.rdy = 1; c.z = z;
      if (opc >= 11) begin
         taken = (opc == 11) || (opc == 12 && z) || (opc == 13 && !z);
         if (taken) c.pc_ld = 1; else c.pc_inc = 1;
         q.push_back(c);
         return;
      end
      c.ar_ld = 1; c.ar_sel = 1; c.pc_inc = 1; q.push_back(c);
      c = base(5);
      if (opc == 2) begin c.wr = 1; c.ac_oe = 1; end
      else begin c.rd = 1; c.alus = 4'(alu_tab[opc]); end
      push_waits(c, w2);
      if (rst_exec) begin q.push_back(rst_cyc(5)); return; end
      c.rdy = 1;
      if (opc != 2) c.ac_ld = 1;
      q.push_back(c);
   endtask

   task automatic pin(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL model_%s: got %0d required %0d", name, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_vec(input cyc_t c);
      return {c.alus, c.ac_ld, c.ac_oe, c.ar_ld, c.ar_sel, c.pc_inc, c.pc_ld,
              c.rd, c.wr, c.halted, c.st};
   endfunction

   initial begin
      int n0;
      logic [15:0] got, exp;

      // pin the model against hand-counted cycle lengths
      n0 = q.size(); add_instr(3, 0, 0, 0, 0, 0);
      pin("add_len", q.size() - n0, 6);
      pin("add_alus", int'(q[q.size()-1].alus), 1);
      pin("add_pcinc2", int'(q[n0+1].pc_inc), 1);
      pin("add_pcinc5", int'(q[n0+4].pc_inc), 1);
      n0 = q.size(); add_instr(1, 3, 3, 3, 0, 0);
      pin("ldac_len", q.size() - n0, 15);
      pin("ldac_alus", int'(q[q.size()-1].alus), 8);
      n0 = q.size(); add_instr(12, 0, 0, 0, 1, 0);
      pin("jmpz_len", q.size() - n0, 5);
      pin("jmpz_pcld", int'(q[q.size()-1].pc_ld), 1);
      add_instr(12, 0, 1, 0, 0, 0);
      add_instr(13, 1, 0, 0, 1, 0);
      add_instr(13, 0, 0, 0, 0, 0);
      n0 = q.size(); add_instr(5, 0, 0, 0, 0, 0);
      pin("inac_len", q.size() - n0, 4);
      add_instr(8, 0, 0, 0, 0, 0);
      add_instr(10, 0, 0, 0, 0, 0);
      add_instr(0, 0, 0, 0, 0, 0);
      add_instr(14, 0, 0, 0, 0, 0);
      add_instr(2, 0, 0, 2, 0, 0);
      add_instr(3, 0, 0, 3, 0, 1);
      add_instr(11, 0, 0, 0, 0, 0);
      for (int i = 0; i < 150; i++)
         add_instr($urandom_range(0, 14), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom), 1'($urandom_range(0, 15) == 0));
      add_instr(15, 1, 0, 0, 0, 0);
      add_instr(3, 0, 1, 1, 0, 0);
      add_instr(5, 0, 0, 0, 0, 0);

      rst = 1'b1; bus_in = 8'h00; mem_ready = 1'b0; z_flag = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      got = {alus, ac_ld, ac_oe, ar_ld, ar_sel, pc_inc, pc_ld, mem_rd, mem_wr, halted, state_dbg};
      if (got !== 16'hF000) begin
         n_bad++;
         $display("FAIL reset_state: got %h required %h", got, 16'hF000);
      end
      @(posedge clk); #1;

      for (int i = 0; i < q.size(); i++) begin
         rst = q[i].rst; bus_in = q[i].bus; mem_ready = q[i].rdy; z_flag = q[i].z;
         @(negedge clk);
         got = {alus, ac_ld, ac_oe, ar_ld, ar_sel, pc_inc, pc_ld, mem_rd, mem_wr, halted, state_dbg};
         exp = exp_vec(q[i]);
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL cycle_%0d {alus,acld,acoe,arld,arsel,pcinc,pcld,rd,wr,halt,st}: got %b required %b",
                     i, got, exp);
         end
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
